onchip_mem_arbiter: RTL and testbench

- Shares one single-port 2500x32 on-chip RAM (Avalon-MM slave: 12-bit word address, 4-bit byteenable, one-cycle read latency) between two Avalon-MM masters.
- Port A is the CPU data master. Port B is the wifi packet DMA.
- Provides round-robin arbitration, out-of-range address trapping, and an optional zero-fill of the whole RAM after reset.
- Sits between the system interconnect and the RAM wrapper; the RAM is driven by this block only.

---
 rtl/onchip_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two Avalon-MM masters sharing one single-port RAM.
// Round-robin grant, out-of-range trapping, optional zero-fill after reset.
module onchip_mem_arbiter #(
    parameter int          DEPTH          = 2500,
    parameter int          ADDR_W         = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [3:0]        a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [31:0]       a_writedata,
    output logic              a_waitrequest,
    output logic              a_readdatavalid,
    output logic [31:0]       a_readdata,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [3:0]        b_byteenable,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [31:0]       b_writedata,
    output logic              b_waitrequest,
    output logic              b_readdatavalid,
    output logic [31:0]       b_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic              busy_clearing,
    output logic              range_err
);

    typedef enum logic {CLEAR, ARB} state_t;

    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
    localparam state_t            RST_STATE = CLEAR_ON_RESET ? CLEAR : ARB;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic              a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic              a_erd_q, a_erd_d, b_erd_q, b_erd_d;
    logic              rerr_q, rerr_d;

    logic a_req, b_req, a_in, b_in, arb_en, a_gnt, b_gnt;
    logic g_in, g_wr, g_rd;

    assign a_req  = a_read | a_write;
    assign b_req  = b_read | b_write;
    assign a_in   = {1'b0, a_address} < DEPTH_W;
    assign b_in   = {1'b0, b_address} < DEPTH_W;
    assign arb_en = reset_n && (state_q == ARB);
    // rr_q low means A wins the next contention
    assign a_gnt  = arb_en && a_req && (!b_req || !rr_q);
    assign b_gnt  = arb_en && b_req && (!a_req || rr_q);

    // Fields of whichever master holds the grant; write beats read
    assign g_in = b_gnt ? b_in : a_in;
    assign g_wr = b_gnt ? b_write : a_write;
    assign g_rd = (b_gnt ? b_read : a_read) & ~g_wr;

    assign a_waitrequest   = !a_gnt;
    assign b_waitrequest   = !b_gnt;
    assign a_readdatavalid = reset_n & (a_pend_q | a_erd_q);
    assign b_readdatavalid = reset_n & (b_pend_q | b_erd_q);
    assign a_readdata      = a_erd_q ? ERR_DATA : mem_readdata;
    assign b_readdata      = b_erd_q ? ERR_DATA : mem_readdata;
    assign range_err       = reset_n & rerr_q;
    assign busy_clearing   = (state_q == CLEAR);
    assign mem_clken       = reset_n;

    // Next state, RAM-side mux and response bookkeeping
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rr_d           = rr_q;
        a_pend_d       = 1'b0;
        b_pend_d       = 1'b0;
        a_erd_d        = 1'b0;
        b_erd_d        = 1'b0;
        rerr_d         = 1'b0;
        mem_address    = '0;
        mem_byteenable = 4'h0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'h0;
        unique case (state_q)
            CLEAR: begin
                if (reset_n) begin
                    mem_chipselect = 1'b1;
                    mem_write      = 1'b1;
                    mem_byteenable = 4'hF;
                    mem_address    = cnt_q;
                    cnt_d          = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ARB;
                    end
                end
            end
            ARB: begin
                if (a_gnt || b_gnt) begin
                    mem_address    = b_gnt ? b_address : a_address;
                    mem_byteenable = b_gnt ? b_byteenable : a_byteenable;
                    mem_writedata  = b_gnt ? b_writedata : a_writedata;
                    mem_chipselect = g_in;
                    mem_write      = g_in & g_wr;
                    a_pend_d       = a_gnt & g_rd & g_in;
                    b_pend_d       = b_gnt & g_rd & g_in;
                    a_erd_d        = a_gnt & g_rd & !g_in;
                    b_erd_d        = b_gnt & g_rd & !g_in;
                    rerr_d         = !g_in;
                    rr_d           = a_gnt;
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
            a_erd_q  <= 1'b0;
            b_erd_q  <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            a_pend_q <= a_pend_d;
            b_pend_q <= b_pend_d;
            a_erd_q  <= a_erd_d;
            b_erd_q  <= b_erd_d;
            rerr_q   <= rerr_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed and randomized checks of the arbiter
// against a word-array reference model and a behavioural RAM.
module tb_onchip_mem_arbiter;

    localparam int          DEPTH = 2500;
    localparam logic [31:0] ERR   = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] a_address = '0, b_address = '0;
    logic [3:0]  a_byteenable = 4'hF, b_byteenable = 4'hF;
    logic        a_read = 1'b0, a_write = 1'b0;
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [31:0] a_writedata = '0, b_writedata = '0;
    logic        a_waitrequest, b_waitrequest;
    logic        a_readdatavalid, b_readdatavalid;
    logic [31:0] a_readdata, b_readdata;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        busy_clearing, range_err;

    int n_pass = 0;
    int n_total = 0;
    bit ptr_b = 1'b0;
    logic [31:0] ref_mem [0:DEPTH-1];

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_address(a_address), .a_byteenable(a_byteenable),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata),
        .a_waitrequest(a_waitrequest), .a_readdatavalid(a_readdatavalid),
        .a_readdata(a_readdata),
        .b_address(b_address), .b_byteenable(b_byteenable),
        .b_read(b_read), .b_write(b_write), .b_writedata(b_writedata),
        .b_waitrequest(b_waitrequest), .b_readdatavalid(b_readdatavalid),
        .b_readdata(b_readdata),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .busy_clearing(busy_clearing), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: garbage preload, one-cycle read latency
    logic [31:0] ram [0:DEPTH-1];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
            ram_loaded <= 1'b1;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < 4; k++)
                    if (mem_byteenable[k])
                        ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        a_read = 1'b1;
        a_address = 12'd0;
        b_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1)
            $display("FAIL rst_wait got a=%b b=%b want 1 1", a_waitrequest, b_waitrequest);
        else n_pass++;
        n_total++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL rst_mem got cs=%b wr=%b want 0 0", mem_chipselect, mem_write);
        else n_pass++;
        n_total++;
        if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0 || range_err !== 1'b0)
            $display("FAIL rst_resp got av=%b bv=%b re=%b want 0", a_readdatavalid, b_readdatavalid, range_err);
        else n_pass++;
        n_total++;
        if (mem_clken !== 1'b0)
            $display("FAIL rst_clken got %b want 0", mem_clken);
        else n_pass++;
        b_read = 1'b0;
    endtask

    task automatic test_clear();
        int cycles = 0;
        int bad = 0;
        int wait_bad = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        while (cycles < 3000) begin
            @(negedge clk);
            if (!busy_clearing) break;
            if (mem_address !== 12'(cycles) || mem_chipselect !== 1'b1 ||
                mem_write !== 1'b1 || mem_writedata !== 32'h0 ||
                mem_byteenable !== 4'hF)
                bad++;
            if (a_waitrequest !== 1'b1) wait_bad++;
            cycles++;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        n_total++;
        if (cycles != DEPTH) $display("FAIL clear_len got %0d want %0d", cycles, DEPTH);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL clear_steps got %0d bad want 0", bad);
        else n_pass++;
        n_total++;
        if (wait_bad != 0) $display("FAIL clear_wait got %0d bad want 0", wait_bad);
        else n_pass++;
        n_total++;
        if (a_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 12'd0)
            $display("FAIL clear_grant got w=%b cs=%b addr=%0d want 0 1 0", a_waitrequest, mem_chipselect, mem_address);
        else n_pass++;
        ptr_b = 1'b1;
        @(posedge clk);
        #1 a_address = 12'd2499;
        @(negedge clk);
        n_total++;
        if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h0)
            $display("FAIL clear_rd0 got v=%b d=%h want 1 0", a_readdatavalid, a_readdata);
        else n_pass++;
        @(posedge clk);
        #1 a_read = 1'b0;
        @(negedge clk);
        n_total++;
        if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h0)
            $display("FAIL clear_rd2499 got v=%b d=%h want 1 0", a_readdatavalid, a_readdata);
        else n_pass++;
    endtask

    task automatic test_byteenable();
        @(posedge clk);
        #1;
        a_write = 1'b1;
        a_address = 12'd5;
        a_writedata = 32'h12345678;
        a_byteenable = 4'b0011;
        @(negedge clk);
        n_total++;
        if (a_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_byteenable !== 4'b0011)
            $display("FAIL be_wr got w=%b mw=%b be=%b want 0 1 0011", a_waitrequest, mem_write, mem_byteenable);
        else n_pass++;
        ref_mem[5] = 32'h00005678;
        @(posedge clk);
        #1;
        a_write = 1'b0;
        a_read = 1'b1;
        a_byteenable = 4'hF;
        @(negedge clk);
        n_total++;
        if (a_readdatavalid !== 1'b0 || a_waitrequest !== 1'b0)
            $display("FAIL be_norsp got v=%b w=%b want 0 0", a_readdatavalid, a_waitrequest);
        else n_pass++;
        @(posedge clk);
        #1 a_read = 1'b0;
        @(negedge clk);
        n_total++;
        if (a_readdatavalid !== 1'b1 || a_readdata !== ref_mem[5])
            $display("FAIL be_rd got v=%b d=%h want 1 %h", a_readdatavalid, a_readdata, ref_mem[5]);
        else n_pass++;
        ptr_b = 1'b1;
    endtask

    task automatic test_contention();
        bit prev_a = 1'b0;
        bit prev_b = 1'b0;
        int a_cnt = 0;
        int b_cnt = 0;
        int bad = 0;
        @(posedge clk);
        #1;
        a_read = 1'b1;
        a_address = 12'd5;
        b_read = 1'b1;
        b_address = 12'd0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                @(posedge clk);
                #1;
                a_read = 1'b0;
                b_read = 1'b0;
            end
            @(negedge clk);
            if (a_readdatavalid !== prev_a || b_readdatavalid !== prev_b) bad++;
            if (a_readdatavalid === 1'b1) begin
                a_cnt++;
                if (a_readdata !== ref_mem[5]) bad++;
            end
            if (b_readdatavalid === 1'b1) begin
                b_cnt++;
                if (b_readdata !== ref_mem[0]) bad++;
            end
            if (i < 8) begin
                n_total++;
                if (a_waitrequest !== ptr_b || b_waitrequest !== !ptr_b)
                    $display("FAIL rr_grant%0d got aw=%b bw=%b want %b %b", i, a_waitrequest, b_waitrequest, ptr_b, !ptr_b);
                else n_pass++;
                prev_a = !ptr_b;
                prev_b = ptr_b;
                ptr_b = !ptr_b;
                if (i != 7) @(posedge clk);
            end
        end
        n_total++;
        if (a_cnt != 4 || b_cnt != 4)
            $display("FAIL rr_pulses got a=%0d b=%0d want 4 4", a_cnt, b_cnt);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL rr_resp got %0d bad want 0", bad);
        else n_pass++;
    endtask

    task automatic test_range_err();
        @(posedge clk);
        #1;
        b_read = 1'b1;
        b_address = 12'd2500;
        @(negedge clk);
        n_total++;
        if (b_waitrequest !== 1'b0 || mem_chipselect !== 1'b0)
            $display("FAIL oor_acc got w=%b cs=%b want 0 0", b_waitrequest, mem_chipselect);
        else n_pass++;
        ptr_b = 1'b0;
        @(posedge clk);
        #1 b_read = 1'b0;
        @(negedge clk);
        n_total++;
        if (range_err !== 1'b1 || b_readdatavalid !== 1'b1 || b_readdata !== ERR)
            $display("FAIL oor_rd got re=%b v=%b d=%h want 1 1 %h", range_err, b_readdatavalid, b_readdata, ERR);
        else n_pass++;
        @(posedge clk);
        #1;
        a_write = 1'b1;
        a_address = 12'd4095;
        @(negedge clk);
        n_total++;
        if (a_waitrequest !== 1'b0 || mem_chipselect !== 1'b0 || range_err !== 1'b0)
            $display("FAIL oor_wr got w=%b cs=%b re=%b want 0 0 0", a_waitrequest, mem_chipselect, range_err);
        else n_pass++;
        ptr_b = 1'b1;
        @(posedge clk);
        #1 a_write = 1'b0;
        @(negedge clk);
        n_total++;
        if (range_err !== 1'b1 || a_readdatavalid !== 1'b0)
            $display("FAIL oor_wrsp got re=%b v=%b want 1 0", range_err, a_readdatavalid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (range_err !== 1'b0) $display("FAIL oor_pulse got %b want 0", range_err);
        else n_pass++;
    endtask

    task automatic test_random(input int n);
        bit ev_a = 1'b0, ev_b = 1'b0, e_re = 1'b0;
        logic [31:0] ed_a = '0, ed_b = '0;
        bit ra, rb, ga, gb, inr, g_wr, g_rd;
        logic [11:0] g_addr;
        logic [3:0] g_be;
        logic [31:0] g_wd;
        int r;
        for (int i = 0; i <= n; i++) begin
            @(posedge clk);
            #1;
            a_read = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_write = (i < n) ? ($urandom_range(0, 3) == 0) : 1'b0;
            b_read = (i < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_write = (i < n) ? ($urandom_range(0, 3) == 0) : 1'b0;
            r = $urandom_range(0, 9);
            a_address = (r == 0) ? 12'($urandom_range(2500, 4095)) :
                        (r == 1) ? 12'($urandom_range(0, 2499)) : 12'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            b_address = (r == 0) ? 12'($urandom_range(2500, 4095)) :
                        (r == 1) ? 12'($urandom_range(0, 2499)) : 12'($urandom_range(0, 15));
            a_byteenable = 4'($urandom);
            b_byteenable = 4'($urandom);
            a_writedata = $urandom;
            b_writedata = $urandom;
            @(negedge clk);
            ra = a_read | a_write;
            rb = b_read | b_write;
            ga = ra && (!rb || !ptr_b);
            gb = rb && (!ra || ptr_b);
            g_addr = gb ? b_address : a_address;
            g_be = gb ? b_byteenable : a_byteenable;
            g_wd = gb ? b_writedata : a_writedata;
            g_wr = gb ? b_write : a_write;
            g_rd = (gb ? b_read : a_read) && !g_wr;
            inr = (g_addr < 12'(DEPTH));
            n_total++;
            if (a_waitrequest !== !ga || b_waitrequest !== !gb)
                $display("FAIL rnd_grant%0d got aw=%b bw=%b want %b %b", i, a_waitrequest, b_waitrequest, !ga, !gb);
            else n_pass++;
            n_total++;
            if (mem_chipselect !== ((ga || gb) && inr))
                $display("FAIL rnd_cs%0d got %b want %b", i, mem_chipselect, (ga || gb) && inr);
            else n_pass++;
            n_total++;
            if (a_readdatavalid !== ev_a || (ev_a && a_readdata !== ed_a))
                $display("FAIL rnd_a%0d got v=%b d=%h want %b %h", i, a_readdatavalid, a_readdata, ev_a, ed_a);
            else n_pass++;
            n_total++;
            if (b_readdatavalid !== ev_b || (ev_b && b_readdata !== ed_b))
                $display("FAIL rnd_b%0d got v=%b d=%h want %b %h", i, b_readdatavalid, b_readdata, ev_b, ed_b);
            else n_pass++;
            n_total++;
            if (range_err !== e_re)
                $display("FAIL rnd_re%0d got %b want %b", i, range_err, e_re);
            else n_pass++;
            ev_a = ga && g_rd;
            ev_b = gb && g_rd;
            ed_a = inr ? ref_mem[g_addr] : ERR;
            ed_b = ed_a;
            e_re = (ga || gb) && !inr;
            if ((ga || gb) && g_wr && inr)
                for (int k = 0; k < 4; k++)
                    if (g_be[k]) ref_mem[g_addr][8*k +: 8] = g_wd[8*k +: 8];
            if (ga) ptr_b = 1'b1;
            if (gb) ptr_b = 1'b0;
        end
    endtask

    task automatic test_reset_pending();
        int cycles = 0;
        @(posedge clk);
        #1;
        a_read = 1'b1;
        a_address = 12'd5;
        @(negedge clk);
        n_total++;
        if (a_waitrequest !== 1'b0) $display("FAIL rp_acc got %b want 0", a_waitrequest);
        else n_pass++;
        @(posedge clk);
        #1;
        a_read = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (a_readdatavalid !== 1'b0) $display("FAIL rp_drop got %b want 0", a_readdatavalid);
        else n_pass++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (a_readdatavalid !== 1'b0 || busy_clearing !== 1'b1 || mem_address !== 12'd0)
            $display("FAIL rp_clr got v=%b busy=%b addr=%0d want 0 1 0", a_readdatavalid, busy_clearing, mem_address);
        else n_pass++;
        repeat (100) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy_clearing !== 1'b1 || mem_address !== 12'd0)
            $display("FAIL mid_clr got busy=%b addr=%0d want 1 0", busy_clearing, mem_address);
        else n_pass++;
        a_read = 1'b1;
        a_address = 12'd7;
        b_read = 1'b1;
        b_address = 12'd9;
        while (cycles < 3000 && busy_clearing === 1'b1) begin
            @(negedge clk);
            cycles++;
        end
        n_total++;
        if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b1)
            $display("FAIL rp_ptr got aw=%b bw=%b want 0 1", a_waitrequest, b_waitrequest);
        else n_pass++;
        @(posedge clk);
        #1 a_read = 1'b0;
        @(negedge clk);
        n_total++;
        if (b_waitrequest !== 1'b0 || a_readdatavalid !== 1'b1 || a_readdata !== 32'h0)
            $display("FAIL rp_next got bw=%b av=%b ad=%h want 0 1 0", b_waitrequest, a_readdatavalid, a_readdata);
        else n_pass++;
        @(posedge clk);
        #1 b_read = 1'b0;
        @(negedge clk);
        n_total++;
        if (b_readdatavalid !== 1'b1 || b_readdata !== 32'h0)
            $display("FAIL rp_brd got v=%b d=%h want 1 0", b_readdatavalid, b_readdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byteenable();
        test_contention();
        test_range_err();
        test_random(400);
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
